// File: rtl/cnt_disp_pkg.sv
// -----------------------------------------------------------------------------
// cnt_disp_pkg
// Shared definitions for the decimal counter display controller:
//   - run-control state encoding (IDLE, RUN, PAUSE)
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 0-9, plus blank
//   - number of display digits
// -----------------------------------------------------------------------------
package cnt_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low 7-segment pattern decoder.
// Any code outside 0-9 produces an all-off (blank) pattern, which the
// scanner relies on to blank a digit.
//
// Ports:
//   digit_i  in   4  BCD digit
//   seg_o    out  7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
    import cnt_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cnt_display_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_display_ctrl
// Run/pause/clear sequencer for a 4-digit BCD up counter (0000-9999) with a
// count-rate prescaler and a time-multiplexed common-anode display scanner.
//
// Build option: define LZ_BLANK_EN to blank leading zeros on the display
// (digit 0 is always shown). Counter outputs are identical in both builds.
//
// Parameters:
//   TICK_DIV  clk cycles per count increment (>= 2)
//   SCAN_DIV  clk cycles per digit-scan step (>= 2)
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   start    in   1   pulse: start / resume counting
//   stop     in   1   pulse: pause counting
//   clear    in   1   pulse: zero the count and stop
//   bcd      out  16  count, digit 3 in [15:12] .. digit 0 in [3:0]
//   seg      out  7   segments {g,f,e,d,c,b,a}, active-low
//   an       out  4   digit anodes, active-low one-hot
//   running  out  1   high while in RUN
//   wrap     out  1   one-cycle pulse on 9999 -> 0000 rollover
//
// State | meaning
// IDLE  | stopped, count held at 0000, prescaler zeroed
// RUN   | prescaler advancing, count increments on each tick
// PAUSE | count and prescaler frozen, resumes with partial period kept
// -----------------------------------------------------------------------------
module cnt_display_ctrl
    import cnt_disp_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        running,
    output logic        wrap
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [15:0]         bcd_q, bcd_d;
    logic                wrap_q, wrap_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;

    logic                tick;
    logic [15:0]         bcd_inc;
    logic                carry;
    logic [3:0]          dig;
    logic [3:0]          digit_raw;
    logic [3:0]          digit_dec;
    logic                lz_blank;

    // ------------------------------------------------------------------
    // Run-control FSM (clear > stop > start)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (!clear && !stop && start) state_d = RUN;
                else                          state_d = IDLE;
            end
            RUN: begin
                if (clear)     state_d = IDLE;
                else if (stop) state_d = PAUSE;
                else           state_d = RUN;
            end
            PAUSE: begin
                if (clear)      state_d = IDLE;
                else if (stop)  state_d = PAUSE;
                else if (start) state_d = RUN;
                else            state_d = PAUSE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Count-rate prescaler
    // ------------------------------------------------------------------
    assign tick = (state_q == RUN) && (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = '0;
        case (state_q)
            RUN:     tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            PAUSE:   tick_cnt_d = tick_cnt_q;
            default: tick_cnt_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // BCD cascade increment
    // ------------------------------------------------------------------
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // The increment is judged against the current state, so a tick in the
    // same cycle as stop still counts; clear overrides it and suppresses wrap.
    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (clear || !((state_q == RUN) || (state_q == PAUSE))) begin
            bcd_d = '0;
        end else if (tick) begin
            bcd_d  = bcd_inc;
            wrap_d = (bcd_q == 16'h9999);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            bcd_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bcd_q      <= bcd_d;
            wrap_q     <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scanner (free-running)
    // ------------------------------------------------------------------
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    assign digit_raw = bcd_q[{idx_q, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
    // Blank a digit when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        lz_blank = 1'b0;
        case (idx_q)
            2'd1:    lz_blank = (bcd_q[15:4]  == 12'h000);
            2'd2:    lz_blank = (bcd_q[15:8]  == 8'h00);
            2'd3:    lz_blank = (bcd_q[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // A non-BCD code decodes to blank.
    assign digit_dec = lz_blank ? 4'hF : digit_raw;

    seg7_decode u_seg7_decode (
        .digit_i (digit_dec),
        .seg_o   (seg_d)
    );

    assign an_d = ~(4'b0001 << idx_q);

    // seg and an share one register stage so a digit never lands on the
    // wrong anode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            seg_q      <= SEG_0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bcd     = bcd_q;
    assign seg     = seg_q;
    assign an      = an_q;
    assign running = (state_q == RUN);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_cnt_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnt_display_ctrl
// Directed bench for cnt_display_ctrl with TICK_DIV = 4, SCAN_DIV = 2.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven
// at the same point so the next rising edge captures them.
// -----------------------------------------------------------------------------
module tb_cnt_display_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        running;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] P_0     = 7'b1000000;
    localparam logic [6:0] P_2     = 7'b0100100;
    localparam logic [6:0] P_4     = 7'b0011001;
    localparam logic [6:0] P_BLANK = 7'b1111111;

    cnt_display_ctrl #(
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .bcd     (bcd),
        .seg     (seg),
        .an      (an),
        .running (running),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bcd(input string tag, input logic [15:0] target, input int max_cyc);
        int n = 0;
        while (bcd !== target && n < max_cyc) begin
            step(1);
            n++;
        end
        check(tag, {16'h0, bcd}, {16'h0, target});
    endtask

    task automatic pulse(input logic s_start, input logic s_stop, input logic s_clear);
        start = s_start;
        stop  = s_stop;
        clear = s_clear;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    logic [6:0] exp_hi;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
`ifdef LZ_BLANK_EN
        exp_hi = P_BLANK;
`else
        exp_hi = P_0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1. reset state and scanner rotation
        check("rst_bcd",     {16'h0, bcd},     32'h0);
        check("rst_an",      {28'h0, an},      32'he);
        check("rst_seg",     {25'h0, seg},     {25'h0, P_0});
        check("rst_running", {31'h0, running}, 32'h0);
        check("rst_wrap",    {31'h0, wrap},    32'h0);
        step(1);
        check("scan_an_e1",  {28'h0, an},  32'he);
        check("scan_seg_e1", {25'h0, seg}, {25'h0, P_0});
        step(1);
        check("scan_an_e2",  {28'h0, an},  32'he);
        step(1);
        check("scan_an_1101", {28'h0, an}, 32'hd);
        step(2);
        check("scan_an_1011", {28'h0, an}, 32'hb);
        step(2);
        check("scan_an_0111", {28'h0, an}, 32'h7);
        step(2);
        check("scan_an_wrap", {28'h0, an}, 32'he);

        // 2. start and count
        pulse(1'b1, 1'b0, 1'b0);
        check("start_running", {31'h0, running}, 32'h1);
        step(3);
        check("pre_first_inc", {16'h0, bcd}, 32'h0);
        step(1);
        check("first_inc",     {16'h0, bcd}, 32'h1);
        step(36);
        check("bcd_after_40",  {16'h0, bcd}, 32'h0010);
        check("wrap_idle_run", {31'h0, wrap}, 32'h0);

        // 3. pause keeps the partial prescaler period
        step(2);
        pulse(1'b0, 1'b1, 1'b0);
        check("stop_running", {31'h0, running}, 32'h0);
        step(20);
        check("pause_frozen", {16'h0, bcd}, 32'h0010);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_running", {31'h0, running}, 32'h1);
        check("resume_bcd",     {16'h0, bcd},     32'h0010);
        step(1);
        check("resume_partial", {16'h0, bcd}, 32'h0011);

        // 4. carry chain and rollover
        wait_bcd("reach_0999", 16'h0999, 5000);
        step(4);
        check("carry_1000", {16'h0, bcd}, 32'h1000);
        wait_bcd("reach_9999", 16'h9999, 40000);
        step(3);
        check("hold_9999",   {16'h0, bcd},  32'h9999);
        check("wrap_before", {31'h0, wrap}, 32'h0);
        step(1);
        check("rollover_bcd",  {16'h0, bcd},  32'h0);
        check("rollover_wrap", {31'h0, wrap}, 32'h1);
        step(1);
        check("wrap_one_cycle", {31'h0, wrap}, 32'h0);
        check("post_wrap_bcd",  {16'h0, bcd},  32'h0);

        // tick together with stop still increments
        step(2);
        step(1);
        check("count_1", {16'h0, bcd}, 32'h1);
        step(4);
        check("count_2", {16'h0, bcd}, 32'h2);
        step(3);
        pulse(1'b0, 1'b1, 1'b0);
        check("tick_stop_bcd",     {16'h0, bcd},     32'h3);
        check("tick_stop_running", {31'h0, running}, 32'h0);

        // 5. clear + stop on a tick, then start + clear in IDLE
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        check("pre_clear_bcd", {16'h0, bcd}, 32'h3);
        pulse(1'b0, 1'b1, 1'b1);
        check("clr_tick_bcd",     {16'h0, bcd},     32'h0);
        check("clr_tick_running", {31'h0, running}, 32'h0);
        check("clr_tick_wrap",    {31'h0, wrap},    32'h0);
        pulse(1'b1, 1'b0, 1'b1);
        check("start_clr_running", {31'h0, running}, 32'h0);
        step(4);
        check("start_clr_bcd",  {16'h0, bcd},     32'h0);
        check("start_clr_idle", {31'h0, running}, 32'h0);

        // stop beats start in PAUSE
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        check("stop_over_start", {31'h0, running}, 32'h0);
        pulse(1'b0, 1'b0, 1'b1);
        check("clear_pause_bcd", {16'h0, bcd}, 32'h0);

        // 6. display at 0042
        pulse(1'b1, 1'b0, 1'b0);
        step(167);
        check("preset_0041", {16'h0, bcd}, 32'h0041);
        step(1);
        check("preset_0042", {16'h0, bcd}, 32'h0042);
        pulse(1'b0, 1'b1, 1'b0);
        step(8);
        for (int i = 0; i < 8; i++) begin
            step(1);
            case (an)
                4'b1110: check("disp_d0", {25'h0, seg}, {25'h0, P_2});
                4'b1101: check("disp_d1", {25'h0, seg}, {25'h0, P_4});
                4'b1011: check("disp_d2", {25'h0, seg}, {25'h0, exp_hi});
                4'b0111: check("disp_d3", {25'h0, seg}, {25'h0, exp_hi});
                default: check("disp_an_onehot", {28'h0, an}, 32'he);
            endcase
        end

        // asynchronous reset mid-count
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(6);
        check("pre_rst_bcd", {16'h0, bcd}, 32'h1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_bcd",     {16'h0, bcd},     32'h0);
        check("async_rst_an",      {28'h0, an},      32'he);
        check("async_rst_seg",     {25'h0, seg},     {25'h0, P_0});
        check("async_rst_running", {31'h0, running}, 32'h0);
        check("async_rst_wrap",    {31'h0, wrap},    32'h0);
        #2 rst = 1'b0;
        step(1);
        check("post_rst_running", {31'h0, running}, 32'h0);
        check("post_rst_bcd",     {16'h0, bcd},     32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
